// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - fetch-queue bus bundle: instruction memory handshake and head-of-queue outputs
//
// Signals:
//   imem_req_o    fetch -> memory   request strobe, one cycle per request
//   imem_addr_o   fetch -> memory   word-aligned request address
//   imem_rvalid_i memory -> fetch   response valid, one cycle
//   imem_rdata_i  memory -> fetch   response instruction word
//   valid_o       fetch -> decode   head entry valid
//   instr_o       fetch -> decode   head instruction (NOP when empty)
//   pc_o          fetch -> decode   PC of head instruction (0 when empty)
// Modports: master = fetch stage, slave = memory / decode side.

interface instr_fetch_queue_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output valid_o,
        output instr_o,
        output pc_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  valid_o,
        input  instr_o,
        input  pc_o
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - IF stage: owns fetch PC, one-outstanding imem requests, instruction FIFO
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   start_i        level; new requests only while high
//   stall_i        hold head entry (no dequeue); pushes still accepted
//   flush_i        discard queue and in-flight fetch, redirect to redirect_pc_i
//   redirect_pc_i  new fetch PC, sampled when flush_i=1
//   bus            instr_fetch_queue_if.master (imem handshake + head outputs)

module instr_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [31:0]            redirect_pc_i,
    instr_fetch_queue_if.master    bus
);

    localparam int              PW   = $clog2(DEPTH);
    localparam logic [PW:0]     FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        DROP
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [31:0]    fetch_pc;
    logic [31:0]    req_pc;

    logic [31:0]    q_instr [DEPTH];
    logic [31:0]    q_pc    [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW:0]    count;

    logic           issue;
    logic           push;
    logic           pop;
    logic           valid;

    assign valid = (count != '0);
    assign pop   = valid && !stall_i && !flush_i;

    // A request is only issued while count<DEPTH, so the returning word
    // always has a free slot even if decode stalls for the whole round trip.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (!start_i) begin
                    state_nxt = IDLE;
                end else if (!flush_i && (count < FULL)) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    // A flush in the same cycle throws the word away.
                    push      = !flush_i;
                    state_nxt = FETCH;
                end else if (flush_i) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                // Response belongs to the pre-flush stream; swallow it.
                if (bus.imem_rvalid_i) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;

            if (flush_i) begin
                fetch_pc <= redirect_pc_i;
            end else if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (flush_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            q_instr[tail] <= bus.imem_rdata_i;
            q_pc[tail]    <= req_pc;
        end
    end

    assign bus.imem_req_o  = issue;
    assign bus.imem_addr_o = issue ? fetch_pc : '0;
    assign bus.valid_o     = valid;
    assign bus.instr_o     = valid ? q_instr[head] : NOP_INSTR;
    assign bus.pc_o        = valid ? q_pc[head] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue with memory model and scoreboard

module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic        flush;
    logic [31:0] redirect;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_pc_i (redirect),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] mq_pc[$];
    logic [31:0] mq_in[$];
    logic [31:0] exp_pc;
    logic [31:0] out_pc;
    bit          outst;
    bit          stale;
    // memory model state
    logic [31:0] mem_addr;
    int          timer;
    int          lat;
    // bookkeeping
    int          cyc;
    int          first_valid;
    int          n_req;
    int          n_pop;
    logic [31:0] popped[$];
    int          req_cyc[$];
    logic [31:0] req_addr[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [31:0] hp;
        logic [31:0] hi;
        @(negedge clk);
        if (bus.imem_req_o) begin
            mem_addr = bus.imem_addr_o;
            timer    = lat;
        end
        if (rst) begin
            mq_pc.delete();
            mq_in.delete();
            exp_pc = RESET_PC;
            outst  = 0;
            stale  = 0;
        end else begin
            hp = (mq_pc.size() != 0) ? mq_pc[0] : 32'h0;
            hi = (mq_in.size() != 0) ? mq_in[0] : NOP;
            chk("valid_o", 32'(bus.valid_o), 32'(mq_pc.size() != 0));
            chk("pc_o", bus.pc_o, hp);
            chk("instr_o", bus.instr_o, hi);
            if (bus.imem_req_o) begin
                chk("req_addr", bus.imem_addr_o, exp_pc);
                chk("req_legal", {28'b0, outst, flush, (mq_pc.size() >= DEPTH), !start}, 32'h0);
                n_req++;
                req_cyc.push_back(cyc);
                req_addr.push_back(bus.imem_addr_o);
            end
            if (bus.valid_o && first_valid < 0) first_valid = cyc;

            if (flush) begin
                mq_pc.delete();
                mq_in.delete();
            end else if (mq_pc.size() != 0 && !stall) begin
                popped.push_back(mq_pc.pop_front());
                void'(mq_in.pop_front());
                n_pop++;
            end
            if (bus.imem_rvalid_i && outst) begin
                if (!flush && !stale) begin
                    mq_pc.push_back(out_pc);
                    mq_in.push_back(mem_word(out_pc));
                end
                outst = 0;
                stale = 0;
            end else if (flush && outst) begin
                stale = 1;
            end
            if (bus.imem_req_o && !flush) begin
                outst  = 1;
                out_pc = exp_pc;
                exp_pc = exp_pc + 32'd4;
            end
            if (flush) exp_pc = redirect;
        end
        cyc++;
        @(posedge clk);
        #1;
        bus.imem_rvalid_i = 1'b0;
        if (timer > 0) begin
            timer--;
            if (timer == 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = mem_word(mem_addr);
            end
        end
    endtask

    task automatic do_reset(input logic s);
        start = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 10 && timer > 0; i++) cycle();
        rst = 1'b1;
        cycle();
        cycle();
        rst         = 1'b0;
        start       = s;
        cyc         = 0;
        first_valid = -1;
        req_cyc.delete();
        req_addr.delete();
        popped.delete();
        #1;
        chk("rst_req", 32'(bus.imem_req_o), 32'h0);
        chk("rst_addr", bus.imem_addr_o, 32'h0);
        chk("rst_valid", 32'(bus.valid_o), 32'h0);
        chk("rst_instr", bus.instr_o, NOP);
        chk("rst_pc", bus.pc_o, 32'h0);
    endtask

    int n0;
    int p0;

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        stall             = 1'b0;
        flush             = 1'b0;
        redirect          = 32'h0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        timer = 0; lat = 1; cyc = 0; first_valid = -1; n_req = 0; n_pop = 0;
        outst = 0; stale = 0; exp_pc = RESET_PC; out_pc = 0; mem_addr = 0;

        // 1: 1-cycle memory, no stall
        lat = 1;
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) cycle();
        chk("t1_req0_cyc", 32'(req_cyc[0]), 32'd1);
        chk("t1_req1_cyc", 32'(req_cyc[1]), 32'd3);
        chk("t1_req2_cyc", 32'(req_cyc[2]), 32'd5);
        chk("t1_req1_addr", req_addr[1], 32'h4);
        chk("t1_req2_addr", req_addr[2], 32'h8);
        chk("t1_first_valid", 32'(first_valid), 32'd3);
        chk("t1_first_pc", popped[0], 32'h0);

        // 2: stall fills queue to DEPTH
        lat = 1;
        do_reset(1'b1);
        stall = 1'b1;
        n0 = n_req;
        for (int i = 0; i < 14; i++) cycle();
        chk("t2_reqs_while_stalled", 32'(n_req - n0), 32'd4);
        chk("t2_head_held", bus.pc_o, 32'h0);
        chk("t2_full_valid", 32'(bus.valid_o), 32'h1);
        stall = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("t2_pop0", popped[0], 32'h0);
        chk("t2_pop1", popped[1], 32'h4);
        chk("t2_pop2", popped[2], 32'h8);
        chk("t2_pop3", popped[3], 32'hC);

        // 3: latency 3, flush while waiting
        lat = 3;
        do_reset(1'b1);
        for (int i = 0; i < 20 && !outst; i++) cycle();
        chk("t3_outstanding", 32'(outst), 32'h1);
        flush    = 1'b1;
        redirect = 32'h40;
        cycle();
        flush = 1'b0;
        popped.delete();
        req_addr.delete();
        for (int i = 0; i < 20; i++) cycle();
        chk("t3_first_req", req_addr[0], 32'h40);
        chk("t3_first_pop", popped[0], 32'h40);

        // 4: flush coincident with rvalid while stalled
        lat = 2;
        do_reset(1'b1);
        stall = 1'b1;
        for (int i = 0; i < 20 && !bus.imem_rvalid_i; i++) cycle();
        chk("t4_rvalid_seen", 32'(bus.imem_rvalid_i), 32'h1);
        flush    = 1'b1;
        redirect = 32'h100;
        cycle();
        flush = 1'b0;
        #1;
        chk("t4_valid_after_flush", 32'(bus.valid_o), 32'h0);
        popped.delete();
        req_addr.delete();
        for (int i = 0; i < 6; i++) cycle();
        stall = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("t4_first_req", req_addr[0], 32'h100);
        chk("t4_first_pop", popped[0], 32'h100);

        // 5: reset during WAIT, response arrives afterwards
        lat = 4;
        do_reset(1'b1);
        for (int i = 0; i < 20 && !outst; i++) cycle();
        cycle();
        rst   = 1'b1;
        start = 1'b0;
        cycle();
        rst = 1'b0;
        n0  = n_req;
        p0  = n_pop;
        for (int i = 0; i < 8; i++) cycle();
        chk("t5_no_req", 32'(n_req - n0), 32'h0);
        chk("t5_no_pop", 32'(n_pop - p0), 32'h0);
        chk("t5_valid", 32'(bus.valid_o), 32'h0);
        chk("t5_instr", bus.instr_o, NOP);
        start = 1'b1;
        req_addr.delete();
        for (int i = 0; i < 10; i++) cycle();
        chk("t5_req_seen", 32'(req_addr.size() > 0), 32'h1);
        chk("t5_first_req", req_addr[0], RESET_PC);

        // 6: start held low
        do_reset(1'b0);
        n0 = n_req;
        for (int i = 0; i < 20; i++) cycle();
        chk("t6_no_req", 32'(n_req - n0), 32'h0);
        chk("t6_instr", bus.instr_o, NOP);
        chk("t6_valid", 32'(bus.valid_o), 32'h0);

        // random traffic against the scoreboard
        lat = 1;
        do_reset(1'b1);
        p0 = n_pop;
        for (int i = 0; i < 1500; i++) begin
            lat      = $urandom_range(1, 4);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            redirect = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                                   : (32'($urandom_range(0, 1023)) << 2);
            if ($urandom_range(0, 49) == 0) start = ~start;
            cycle();
        end
        start = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 30; i++) cycle();
        chk("rand_drained", 32'(bus.valid_o), 32'h0);
        chk("rand_progress", 32'((n_pop - p0) > 100), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
